brownout_filter: RTL and testbench

- Digital back-end for the brownout comparator; consumes its `dout`, which is asynchronous to `clk`.
- Comparator convention: `dout`=0 means supply below threshold, i.e. a brownout condition.
- The block synchronizes `dout`, blanks it during comparator settling after enable, and debounces it with programmable assert/release counts.
- It produces a clean brownout level, one-cycle rise and fall pulses, and a ready indication for the reset/interrupt logic downstream.

---
 rtl/brownout_filter_if.sv | 36 +++
 rtl/brownout_filter.sv | 173 +++++++++++++++++
 tb/tb_brownout_filter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/brownout_filter_if.sv
// Signal bundle between the brownout comparator back-end and its user.
// The brout_flag/clr_flag pair exists only when BROWNOUT_FILTER_STICKY_EN is defined.
interface brownout_filter_if #(
   parameter int CNT_W = 8
);
   logic             ena;
   logic             dcomp;
   logic [CNT_W-1:0] assert_cnt;
   logic [CNT_W-1:0] release_cnt;
   logic             ready;
   logic             brout;
   logic             brout_rise;
   logic             brout_fall;
`ifdef BROWNOUT_FILTER_STICKY_EN
   logic             clr_flag;
   logic             brout_flag;

   modport master (
      output ena, dcomp, assert_cnt, release_cnt, clr_flag,
      input  ready, brout, brout_rise, brout_fall, brout_flag
   );
   modport slave (
      input  ena, dcomp, assert_cnt, release_cnt, clr_flag,
      output ready, brout, brout_rise, brout_fall, brout_flag
   );
`else
   modport master (
      output ena, dcomp, assert_cnt, release_cnt,
      input  ready, brout, brout_rise, brout_fall
   );
   modport slave (
      input  ena, dcomp, assert_cnt, release_cnt,
      output ready, brout, brout_rise, brout_fall
   );
`endif
endinterface

// File: rtl/brownout_filter.sv
// Brownout comparator back-end: synchronizer, settle blanking and assert/release debounce.
// Define BROWNOUT_FILTER_STICKY_EN to add the sticky brout_flag with clr_flag.
module brownout_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int SETTLE_CYC  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   brownout_filter_if.slave  bus
);

   typedef enum logic [2:0] {
      S_OFF,
      S_SETTLE,
      S_NORMAL,
      S_PEND_ASSERT,
      S_BROWNOUT,
      S_PEND_RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ds;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_W:0]   cnt_p1;
   logic [CNT_W-1:0] assert_thr, release_thr;
   logic             ready_q, ready_d;
   logic             brout_q, brout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // Reset value 0 reads as "supply low"; settle blanking hides it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.dcomp};
   end

   assign ds = sync_q[SYNC_STAGES-1];

   // A programmed count of 0 behaves as 1.
   assign assert_thr  = (bus.assert_cnt  == '0) ? CNT_ONE : bus.assert_cnt;
   assign release_thr = (bus.release_cnt == '0) ? CNT_ONE : bus.release_cnt;
   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
   assign cnt_p1      = {1'b0, cnt_q} + (CNT_W+1)'(1);

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!bus.ena) begin
         state_d = S_OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
            S_SETTLE: begin
               if (cnt_q >= SETTLE_LAST) begin
                  state_d = S_NORMAL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_NORMAL: begin
               cnt_d = '0;
               if (!ds) begin
                  if (assert_thr == CNT_ONE) begin
                     state_d = S_BROWNOUT;
                     rise_d  = 1'b1;
                  end else begin
                     state_d = S_PEND_ASSERT;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            S_PEND_ASSERT: begin
               if (ds) begin
                  state_d = S_NORMAL;
                  cnt_d   = '0;
               end else if (cnt_p1 >= {1'b0, assert_thr}) begin
                  state_d = S_BROWNOUT;
                  cnt_d   = '0;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_BROWNOUT: begin
               cnt_d = '0;
               if (ds) begin
                  if (release_thr == CNT_ONE) begin
                     state_d = S_NORMAL;
                     fall_d  = 1'b1;
                  end else begin
                     state_d = S_PEND_RELEASE;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            S_PEND_RELEASE: begin
               if (!ds) begin
                  state_d = S_BROWNOUT;
                  cnt_d   = '0;
               end else if (cnt_p1 >= {1'b0, release_thr}) begin
                  state_d = S_NORMAL;
                  cnt_d   = '0;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = S_OFF;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they change on the transition edge.
   assign ready_d = (state_d == S_NORMAL) || (state_d == S_PEND_ASSERT) ||
                    (state_d == S_BROWNOUT) || (state_d == S_PEND_RELEASE);
   assign brout_d = (state_d == S_BROWNOUT) || (state_d == S_PEND_RELEASE);

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         brout_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         brout_q <= brout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign bus.ready      = ready_q;
   assign bus.brout      = brout_q;
   assign bus.brout_rise = rise_q;
   assign bus.brout_fall = fall_q;

`ifdef BROWNOUT_FILTER_STICKY_EN
   logic flag_q;

   // The set covers both the rise edge and the cycle rise is visible, so a clear there loses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 flag_q <= 1'b0;
      else if (rise_d || rise_q)  flag_q <= 1'b1;
      else if (bus.clr_flag)      flag_q <= 1'b0;
   end

   assign bus.brout_flag = flag_q;
`endif

endmodule

// File: tb/tb_brownout_filter.sv
// Self-checking bench for brownout_filter: expected per-cycle outputs are queued, then popped and
// compared after each clock edge. Define BROWNOUT_FILTER_STICKY_EN to also exercise brout_flag.
module tb_brownout_filter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   brownout_filter_if #(.CNT_W(8)) bus ();

   brownout_filter #(
      .SYNC_STAGES (2),
      .CNT_W       (8),
      .SETTLE_CYC  (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Packed order: ready, brout, brout_rise, brout_fall
   typedef struct packed {
      logic ready;
      logic brout;
      logic rise;
      logic fall;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic exp_t observe();
      return exp_t'({bus.ready, bus.brout, bus.brout_rise, bus.brout_fall});
   endfunction

   task automatic test_reset();
      exp_t obs, e;
      rst_n           = 1'b0;
      bus.ena         = 1'b0;
      bus.dcomp       = 1'b0;
      bus.assert_cnt  = 8'd4;
      bus.release_cnt = 8'd1;
`ifdef BROWNOUT_FILTER_STICKY_EN
      bus.clr_flag    = 1'b0;
`endif
      #12;
      obs = observe();
      n_cmp++;
      if (obs !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_outputs: got rbrf=%b want 0000", obs);
      end
`ifdef BROWNOUT_FILTER_STICKY_EN
      n_cmp++;
      if (bus.brout_flag !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flag: got %b want 0", bus.brout_flag);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // ena=1 from iteration 0; ready after 16 edges; dcomp low then high never reaches 4 lows.
      for (int i = 0; i < 23; i++)
         exp_q.push_back(exp_t'{ready: (i >= 16), brout: 1'b0, rise: 1'b0, fall: 1'b0});
      for (int i = 0; i < 23; i++) begin
         bus.ena   = 1'b1;
         bus.dcomp = (i >= 17);
         @(posedge clk);
         #1;
         obs = observe();
         e   = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL settle[%0d]: got rbrf=%b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_assert_latency();
      exp_t obs, e;
      bus.assert_cnt = 8'd4;
      for (int i = 0; i < 10; i++)
         exp_q.push_back(exp_t'{ready: 1'b1, brout: (i >= 5), rise: (i == 5), fall: 1'b0});
      for (int i = 0; i < 10; i++) begin
         bus.dcomp = 1'b0;
         @(posedge clk);
         #1;
         obs = observe();
         e   = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL assert_latency[%0d]: got rbrf=%b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_release_zero();
      exp_t obs, e;
      bus.release_cnt = 8'd0;
      for (int i = 0; i < 6; i++)
         exp_q.push_back(exp_t'{ready: 1'b1, brout: (i < 2), rise: 1'b0, fall: (i == 2)});
      for (int i = 0; i < 6; i++) begin
         bus.dcomp = 1'b1;
         @(posedge clk);
         #1;
         obs = observe();
         e   = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL release_zero[%0d]: got rbrf=%b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_counts();
      exp_t obs, e;
      // assert_cnt=0 acts as 1 (3 edges); release_cnt=3 gives 5 edges.
      bus.assert_cnt  = 8'd0;
      bus.release_cnt = 8'd3;
      for (int i = 0; i < 11; i++)
         exp_q.push_back(exp_t'{ready: 1'b1, brout: (i >= 2 && i < 8),
                                rise: (i == 2), fall: (i == 8)});
      for (int i = 0; i < 11; i++) begin
         bus.dcomp = (i >= 4);
         @(posedge clk);
         #1;
         obs = observe();
         e   = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL counts[%0d]: got rbrf=%b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_glitch();
      exp_t obs, e;
      logic pat [20];
      bus.assert_cnt = 8'd4;
      for (int i = 0; i < 20; i++)
         pat[i] = (i == 3) || (i >= 7 && i <= 10);
      for (int i = 0; i < 20; i++)
         exp_q.push_back(exp_t'{ready: 1'b1, brout: (i >= 16), rise: (i == 16), fall: 1'b0});
      for (int i = 0; i < 20; i++) begin
         bus.dcomp = pat[i];
         @(posedge clk);
         #1;
         obs = observe();
         e   = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL glitch[%0d]: got rbrf=%b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_disable();
      exp_t obs, e;
      bus.release_cnt = 8'd2;
      // Disable for one cycle while in brownout, then re-enable: full settle again.
      for (int i = 0; i < 20; i++)
         exp_q.push_back(exp_t'{ready: (i >= 17), brout: 1'b0, rise: 1'b0, fall: 1'b0});
      for (int i = 0; i < 20; i++) begin
         bus.ena   = (i != 0);
         bus.dcomp = (i != 0);
         @(posedge clk);
         #1;
         obs = observe();
         e   = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL disable[%0d]: got rbrf=%b want %b", i, obs, e);
         end
      end
   endtask

`ifdef BROWNOUT_FILTER_STICKY_EN
   task automatic test_sticky();
      exp_t obs, e;
      logic exp_flag [14];
      // Flag was set by earlier rises and must have survived release and ena=0.
      n_cmp++;
      if (bus.brout_flag !== 1'b1) begin
         n_err++;
         $display("FAIL sticky_persist: got %b want 1", bus.brout_flag);
      end
      bus.assert_cnt  = 8'd1;
      bus.release_cnt = 8'd1;
      for (int i = 0; i < 14; i++) begin
         exp_flag[i] = (i >= 3 && i <= 8);
         exp_q.push_back(exp_t'{ready: 1'b1, brout: (i >= 3 && i < 7),
                                rise: (i == 3), fall: (i == 7)});
      end
      for (int i = 0; i < 14; i++) begin
         bus.dcomp    = !(i >= 1 && i <= 4);
         bus.clr_flag = (i == 0) || (i == 4) || (i == 9);
         @(posedge clk);
         #1;
         obs = observe();
         e   = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL sticky_out[%0d]: got rbrf=%b want %b", i, obs, e);
         end
         n_cmp++;
         if (bus.brout_flag !== exp_flag[i]) begin
            n_err++;
            $display("FAIL sticky_flag[%0d]: got %b want %b", i, bus.brout_flag, exp_flag[i]);
         end
      end
      bus.clr_flag = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_assert_latency();
      test_release_zero();
      test_counts();
      test_glitch();
      test_disable();
`ifdef BROWNOUT_FILTER_STICKY_EN
      test_sticky();
`endif
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
